uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one UART transmitter between NUM_REQ byte requesters.
- Selects a winner, latches its byte, and drives TX_DATA / TX_DATA_VALID into the UART TX.
- Sequences against TX_BUSY so only one byte is in flight at a time.
- Runs in the TX clock domain, next to the UART wrapper.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 107 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and UART TX signal bundle for uart_tx_arbiter
//   req/req_data : level requests and flattened bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt/grant_id : one-cycle one-hot capture pulse and index of last winner
//   tx_data/tx_data_valid/tx_busy : UART TX data path and handshake
//   active/tx_timeout : arbiter busy flag and start-timeout pulse
//   slave modport is the arbiter side; master is the requesters plus UART side
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [ID_W-1:0]               grant_id;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_data_valid;
  logic                          tx_busy;
  logic                          active;
  logic                          tx_timeout;
  modport master (
    output req, req_data, tx_busy,
    input  gnt, grant_id, tx_data, tx_data_valid, active, tx_timeout
  );
  modport slave (
    input  req, req_data, tx_busy,
    output gnt, grant_id, tx_data, tx_data_valid, active, tx_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters
//   clk   : TX clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_tx_arbiter_if.slave (requests, grants, UART TX data/valid/busy, active, tx_timeout)
//   Optional macro UART_ARB_TIMEOUT_EN: abort WAIT_START after TIMEOUT_CYCLES without tx_busy,
//   pulsing tx_timeout; without it tx_timeout is tied 0 and WAIT_START waits indefinitely.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic          clk,
  input logic          rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;
  state_t                state;
  logic [ID_W-1:0]       last;
  logic [ID_W-1:0]       win;
  logic [ID_W-1:0]       idx;
  logic [NUM_REQ-1:0]    gnt;
  logic [ID_W-1:0]       grant_id;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_data_valid;
  logic                  active;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]      cnt;
  logic                  tx_timeout;
`endif
  // Scan from the farthest candidate to the nearest so the requester closest after last wins.
  always_comb begin
    win = last;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last) + k) % NUM_REQ);
      win = bus.req[idx] ? idx : win;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= ID_W'(NUM_REQ - 1);
      gnt           <= '0;
      grant_id      <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      active        <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt           <= '0;
      tx_timeout    <= 1'b0;
`endif
    end else begin
      gnt           <= '0;
      tx_data_valid <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      tx_timeout    <= 1'b0;
`endif
      case (state)
        IDLE: if (|bus.req && !bus.tx_busy) begin
          tx_data  <= bus.req_data[win*DATA_WIDTH +: DATA_WIDTH];
          gnt      <= NUM_REQ'(1) << win;
          grant_id <= win;
          last     <= win;
          active   <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: begin
          tx_data_valid <= 1'b1;
          state         <= WAIT_START;
`ifdef UART_ARB_TIMEOUT_EN
          cnt           <= '0;
`endif
        end
        WAIT_START: begin
`ifdef UART_ARB_TIMEOUT_EN
          cnt <= cnt + 1'b1;
          if (bus.tx_busy) state <= WAIT_DONE;
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            tx_timeout <= 1'b1;
            active     <= 1'b0;
            state      <= IDLE;
          end
`else
          if (bus.tx_busy) state <= WAIT_DONE;
`endif
        end
        WAIT_DONE: if (!bus.tx_busy) begin
          active <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.gnt           = gnt;
  assign bus.grant_id      = grant_id;
  assign bus.tx_data       = tx_data;
  assign bus.tx_data_valid = tx_data_valid;
  assign bus.active        = active;
`ifdef UART_ARB_TIMEOUT_EN
  assign bus.tx_timeout    = tx_timeout;
`else
  assign bus.tx_timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven, directed and randomized checks of uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  int busy_left  = 0;
  int start_left = 0;
  int uart_delay = 2;
  int uart_len   = 10;
  bit uart_auto  = 1'b1;
  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    int          exp_id;
  } vec_t;
  vec_t vecs[12];
  uart_tx_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus();
  uart_tx_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // UART model: busy rises uart_delay cycles after valid, stays high uart_len cycles.
  task automatic uart_step();
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) bus.tx_busy = 1'b0;
    end
    if (start_left > 0) begin
      start_left--;
      if (start_left == 0) begin
        bus.tx_busy = 1'b1;
        busy_left   = uart_len;
      end
    end
    if (uart_auto && bus.tx_data_valid) start_left = uart_delay;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    uart_step();
  endtask
  task automatic wait_gnt(string name);
    int n = 0;
    while (bus.gnt == 0 && n < 100) begin
      tick();
      n++;
    end
    chk({name, " gnt wait"}, 32'(bus.gnt != 0), 1);
  endtask
  task automatic wait_idle(string name);
    int n = 0;
    while (bus.active && n < 200) begin
      tick();
      n++;
    end
    chk({name, " idle wait"}, 32'(bus.active), 0);
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    busy_left   = 0;
    start_left  = 0;
    bus.tx_busy = 1'b0;
    bus.req     = '0;
    chk("rst gnt", 32'(bus.gnt), 0);
    chk("rst grant_id", 32'(bus.grant_id), 0);
    chk("rst tx_data", 32'(bus.tx_data), 0);
    chk("rst valid", 32'(bus.tx_data_valid), 0);
    chk("rst active", 32'(bus.active), 0);
    chk("rst timeout", 32'(bus.tx_timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask
  task automatic run_vec(vec_t v, string name);
    logic [7:0] b;
    b = v.data[v.exp_id*8 +: 8];
    bus.req      = v.req;
    bus.req_data = v.data;
    wait_gnt(name);
    chk({name, " gnt"}, 32'(bus.gnt), 32'(1) << v.exp_id);
    chk({name, " grant_id"}, 32'(bus.grant_id), v.exp_id);
    chk({name, " tx_data"}, 32'(bus.tx_data), 32'(b));
    chk({name, " valid early"}, 32'(bus.tx_data_valid), 0);
    chk({name, " active"}, 32'(bus.active), 1);
    bus.req = '0;
    tick();
    chk({name, " valid"}, 32'(bus.tx_data_valid), 1);
    chk({name, " gnt drop"}, 32'(bus.gnt), 0);
    chk({name, " tx_data hold"}, 32'(bus.tx_data), 32'(b));
    wait_idle(name);
  endtask
  function automatic int pick(logic [3:0] r, int last);
    int best = -1;
    int bd   = NR;
    for (int i = 0; i < NR; i++) begin
      int d;
      d = (i - last - 1 + 2 * NR) % NR;
      if (r[i] && d < bd) begin
        bd   = d;
        best = i;
      end
    end
    return best;
  endfunction
  initial begin
    logic [3:0]  prev_req;
    logic [31:0] prev_data;
    logic        prev_busy;
    logic [7:0]  exp_byte;
    bit          exp_vld;
    int          last_ref, gen, granted, w, n;
    int          waitc[NR];
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_busy  = 1'b0;
    vecs[0]  = '{4'b0100, 32'h13A5_1110, 2};
    vecs[1]  = '{4'b1111, 32'h1312_1110, 3};
    vecs[2]  = '{4'b1001, 32'h1312_1110, 0};
    vecs[3]  = '{4'b1001, 32'h1312_1110, 3};
    vecs[4]  = '{4'b1111, 32'hC3B2_A190, 0};
    vecs[5]  = '{4'b1111, 32'hC3B2_A190, 1};
    vecs[6]  = '{4'b0001, 32'h0000_005A, 0};
    vecs[7]  = '{4'b0001, 32'h0000_00E7, 0};
    vecs[8]  = '{4'b0110, 32'h0044_3300, 1};
    vecs[9]  = '{4'b0110, 32'h0044_3300, 2};
    vecs[10] = '{4'b1010, 32'h7700_6600, 3};
    vecs[11] = '{4'b1010, 32'h7700_6600, 1};
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle gnt", 32'(bus.gnt), 0);
      chk("idle valid", 32'(bus.tx_data_valid), 0);
      chk("idle active", 32'(bus.active), 0);
    end
    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    bus.tx_busy = 1'b1;
    bus.req     = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy gate gnt", 32'(bus.gnt), 0);
    end
    bus.tx_busy = 1'b0;
    tick();
    chk("busy release gnt", 32'(bus.gnt), 1);
    bus.req = '0;
    tick();
    wait_idle("busy gate");
    do_reset();
    bus.req      = 4'b1111;
    bus.req_data = 32'h1312_1110;
    for (int g = 0; g < 5; g++) begin
      wait_gnt("contend");
      chk("contend gnt", 32'(bus.gnt), 32'(1) << (g % NR));
      chk("contend tx_data", 32'(bus.tx_data), 32'h10 + 32'(g % NR));
      tick();
      chk("contend valid", 32'(bus.tx_data_valid), 1);
      wait_idle("contend");
    end
    bus.req = 4'b0001;
    wait_gnt("rst mid");
    bus.req = '0;
    tick();
    n = 0;
    while (!bus.tx_busy && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk("rst mid active", 32'(bus.active), 1);
    do_reset();
    run_vec('{4'b0011, 32'h0000_BBAA, 0}, "post rst ptr");
    run_vec('{4'b0010, 32'h0000_CC00, 1}, "post rst single");
    bus.req = 4'b0100;
    wait_gnt("rst issue");
    bus.req = '0;
    tick();
    chk("rst issue valid", 32'(bus.tx_data_valid), 1);
    do_reset();
`ifdef UART_ARB_TIMEOUT_EN
    uart_auto    = 1'b0;
    bus.req      = 4'b0011;
    bus.req_data = 32'h0000_2211;
    wait_gnt("tmo");
    chk("tmo gnt", 32'(bus.gnt), 1);
    bus.req = 4'b0010;
    tick();
    chk("tmo valid", 32'(bus.tx_data_valid), 1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("tmo early", 32'(bus.tx_timeout), 0);
      chk("tmo active", 32'(bus.active), 1);
    end
    tick();
    chk("tmo pulse", 32'(bus.tx_timeout), 1);
    chk("tmo idle", 32'(bus.active), 0);
    uart_auto = 1'b1;
    tick();
    chk("tmo pulse end", 32'(bus.tx_timeout), 0);
    chk("tmo next gnt", 32'(bus.gnt), 32'b0010);
    chk("tmo next data", 32'(bus.tx_data), 32'h22);
    bus.req = '0;
    tick();
    wait_idle("tmo");
`else
    uart_auto = 1'b0;
    bus.req   = 4'b0001;
    wait_gnt("hold");
    bus.req = '0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold timeout", 32'(bus.tx_timeout), 0);
    end
    chk("hold active", 32'(bus.active), 1);
    uart_auto = 1'b1;
`endif
    do_reset();
    exp_vld  = 1'b0;
    exp_byte = '0;
    last_ref = NR - 1;
    gen      = 0;
    granted  = 0;
    for (int i = 0; i < NR; i++) waitc[i] = 0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (gen >= 300 && bus.req == 0 && !bus.active && !exp_vld) break;
      for (int i = 0; i < NR; i++)
        if (!bus.req[i] && gen < 300 && $urandom_range(0, 5) == 0) begin
          bus.req[i]           = 1'b1;
          bus.req_data[i*8+:8] = 8'($urandom);
          waitc[i]             = 0;
          gen++;
        end
      prev_req   = bus.req;
      prev_data  = bus.req_data;
      prev_busy  = bus.tx_busy;
      uart_delay = $urandom_range(1, 3);
      uart_len   = $urandom_range(1, 6);
      tick();
      chk("rnd valid", 32'(bus.tx_data_valid), 32'(exp_vld));
      if (exp_vld) chk("rnd valid data", 32'(bus.tx_data), 32'(exp_byte));
      chk("rnd timeout", 32'(bus.tx_timeout), 0);
      exp_vld = 1'b0;
      if (bus.gnt != 0) begin
        w = pick(prev_req, last_ref);
        if (w < 0) chk("rnd spurious gnt", 32'(bus.gnt), 0);
        else begin
          exp_byte = prev_data[w*8 +: 8];
          chk("rnd gnt", 32'(bus.gnt), 32'(1) << w);
          chk("rnd grant_id", 32'(bus.grant_id), w);
          chk("rnd tx_data", 32'(bus.tx_data), 32'(exp_byte));
          chk("rnd busy gate", 32'(prev_busy), 0);
          chk("rnd fairness", 32'(waitc[w] <= NR - 1), 1);
          for (int i = 0; i < NR; i++) if (i != w && prev_req[i]) waitc[i]++;
          waitc[w] = 0;
          last_ref = w;
          granted++;
          exp_vld = 1'b1;
          if ($urandom_range(0, 1) == 1 && gen < 300) begin
            bus.req_data[w*8+:8] = 8'($urandom);
            gen++;
          end else bus.req[w] = 1'b0;
        end
      end
    end
    chk("rnd all granted", granted, gen);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
